// File: rtl/branch_predictor_pht_pkg.sv
// rtl/branch_predictor_pht_pkg.sv - shared constants and helpers for the PHT
package branch_predictor_pht_pkg;

   // Mirrors PRED_GHR_W for use in elaboration-time localparams.
   function automatic int ghr_width(input int ghr_bits);
      return (ghr_bits > 0) ? ghr_bits : 1;
   endfunction

   localparam int PC_IDX_LO = 2;

endpackage

// File: rtl/branch_predictor_pht_sat_counter_next.sv
// rtl/branch_predictor_pht_sat_counter_next.sv - saturating counter next-state
//
// Purpose: combinational next value of a CNT_WIDTH-bit up/down counter that
//          saturates at 0 and 2^CNT_WIDTH-1 instead of wrapping.
// Ports:   cur   - current counter value
//          taken - 1 = count up, 0 = count down
//          next  - saturated next value
module sat_counter_next #(
   parameter int CNT_WIDTH = 2
) (
   input  logic [CNT_WIDTH-1:0] cur,
   input  logic                 taken,
   output logic [CNT_WIDTH-1:0] next
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   always_comb begin
      next = cur;
      if (taken) begin
         if (cur != CNT_MAX) next = cur + 1'b1;
      end else begin
         if (cur != '0) next = cur - 1'b1;
      end
   end

endmodule

// File: rtl/predictor_defs.vh
// rtl/predictor_defs.vh - shared macros for predictor tables (PHT, BTB)
`ifndef PREDICTOR_DEFS_VH
`define PREDICTOR_DEFS_VH

// Reset value of a w-bit saturating counter: weakly not-taken (01 for w=2).
`define PRED_CNT_RESET(w) ((1 << ((w) - 1)) - 1)

// Table indices skip the two byte-offset bits of a word-aligned PC.
`define PRED_IDX_LO 2
`define PRED_IDX_HI(b) ((b) + 1)
`define PRED_DEPTH(b) (1 << (b))

// History register width; a zero-length history still gets one port bit.
`define PRED_GHR_W(g) (((g) > 0) ? (g) : 1)

`endif

// File: rtl/branch_predictor_pht.sv
// rtl/branch_predictor_pht.sv - pattern history table branch predictor
//
// Purpose: bimodal (GHR_BITS=0) or gshare table of saturating counters with a
//          one-cycle registered lookup and non-speculative global history.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          pred_valid, pred_pc         - lookup request
//          pred_out_valid, pred_taken  - registered lookup result
//          upd_valid, upd_pc, upd_taken- resolved-branch training
//          ghr_out                     - current global history (0 if bimodal)
`include "predictor_defs.vh"

module branch_predictor_pht
   import branch_predictor_pht_pkg::*;
#(
   parameter int CNT_WIDTH  = 2,
   parameter int INDEX_BITS = 4,
   parameter int GHR_BITS   = 0,
   parameter int PC_WIDTH   = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              pred_valid,
   input  logic [PC_WIDTH-1:0]               pred_pc,
   output logic                              pred_out_valid,
   output logic                              pred_taken,
   input  logic                              upd_valid,
   input  logic [PC_WIDTH-1:0]               upd_pc,
   input  logic                              upd_taken,
   output logic [`PRED_GHR_W(GHR_BITS)-1:0]  ghr_out
);

   localparam int DEPTH = `PRED_DEPTH(INDEX_BITS);
   localparam int GW    = ghr_width(GHR_BITS);
   localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(`PRED_CNT_RESET(CNT_WIDTH));

   // Flop array rather than RAM so every entry can be cleared in one cycle.
   logic [CNT_WIDTH-1:0]  table_q [DEPTH];
   logic [CNT_WIDTH-1:0]  table_d [DEPTH];
   logic [GW-1:0]         ghr_q, ghr_d;
   logic                  pred_out_valid_q, pred_out_valid_d;
   logic                  pred_taken_q, pred_taken_d;

   logic [INDEX_BITS-1:0] ghr_ext;
   logic [INDEX_BITS-1:0] pred_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [CNT_WIDTH-1:0]  upd_next;

   // Only pc[INDEX_BITS+1:2] selects an entry; the rest is aliased away.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc, upd_pc};

   // Both indices hash with the pre-shift history. When bimodal, ghr_q is
   // pinned to zero so the XOR vanishes.
   always_comb begin
      ghr_ext         = '0;
      ghr_ext[GW-1:0] = ghr_q;
      pred_idx = pred_pc[`PRED_IDX_HI(INDEX_BITS):PC_IDX_LO] ^ ghr_ext;
      upd_idx  = upd_pc[`PRED_IDX_HI(INDEX_BITS):PC_IDX_LO] ^ ghr_ext;
   end

   sat_counter_next #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_sat_counter_next (
      .cur   (table_q[upd_idx]),
      .taken (upd_taken),
      .next  (upd_next)
   );

   // At most the one update entry changes each cycle.
   always_comb begin
      table_d = table_q;
      if (upd_valid) table_d[upd_idx] = upd_next;
   end

   always_comb begin
      ghr_d = ghr_q;
      if ((GHR_BITS > 0) && upd_valid) ghr_d = (ghr_q << 1) | GW'(upd_taken);
   end

   // Reading the post-update table forwards a same-cycle update to the lookup.
   always_comb begin
      pred_out_valid_d = pred_valid;
      pred_taken_d     = pred_taken_q;
      if (pred_valid) pred_taken_d = table_d[pred_idx][CNT_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= CNT_RST;
         ghr_q            <= '0;
         pred_out_valid_q <= 1'b0;
         pred_taken_q     <= 1'b0;
      end else begin
         table_q          <= table_d;
         ghr_q            <= ghr_d;
         pred_out_valid_q <= pred_out_valid_d;
         pred_taken_q     <= pred_taken_d;
      end
   end

   assign pred_out_valid = pred_out_valid_q;
   assign pred_taken     = pred_taken_q;
   assign ghr_out        = ghr_q;

endmodule

// File: tb/tb_branch_predictor_pht.sv
// tb/tb_branch_predictor_pht.sv - directed bench for branch_predictor_pht
module tb_branch_predictor_pht;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        pred_valid = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;

   logic       ov0, tk0;
   logic [0:0] ghr0;
   logic       ov1, tk1;
   logic [1:0] ghr1;
   logic       ov2, tk2;
   logic [0:0] ghr2;

   int vectors     = 0;
   int miscompares = 0;

   // Default bimodal table.
   branch_predictor_pht u_dut_bim (
      .clk (clk), .rst (rst),
      .pred_valid (pred_valid), .pred_pc (pred_pc),
      .pred_out_valid (ov0), .pred_taken (tk0),
      .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_taken (upd_taken),
      .ghr_out (ghr0)
   );

   // Two-bit gshare.
   branch_predictor_pht #(.GHR_BITS (2)) u_dut_gsh (
      .clk (clk), .rst (rst),
      .pred_valid (pred_valid), .pred_pc (pred_pc),
      .pred_out_valid (ov1), .pred_taken (tk1),
      .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_taken (upd_taken),
      .ghr_out (ghr1)
   );

   // Three-bit counters.
   branch_predictor_pht #(.CNT_WIDTH (3)) u_dut_c3 (
      .clk (clk), .rst (rst),
      .pred_valid (pred_valid), .pred_pc (pred_pc),
      .pred_out_valid (ov2), .pred_taken (tk2),
      .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_taken (upd_taken),
      .ghr_out (ghr2)
   );

   typedef struct {
      logic        r;
      logic        pv;
      logic [31:0] ppc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic        exp_ov;
      logic        exp_tk;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic pv, input logic [31:0] ppc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic exp_ov, input logic exp_tk);
      vec_t v;
      v.r = r; v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.exp_ov = exp_ov; v.exp_tk = exp_tk;
      vq.push_back(v);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic drive(input logic r, input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ut);
      rst = r; pred_valid = pv; pred_pc = ppc;
      upd_valid = uv; upd_pc = upc; upd_taken = ut;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   initial begin
      // Bimodal table: {rst, pv, pred_pc, uv, upd_pc, ut, exp_ov, exp_taken}
      add(1, 0, 32'h00, 0, 32'h00, 0, 0, 0);  // reset
      add(1, 1, 32'h40, 0, 32'h00, 0, 0, 0);  // lookup in reset cycle dropped
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 0);  // counter 01
      add(0, 0, 32'h00, 0, 32'h00, 0, 0, 0);
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 10
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 11
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 11
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 11
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 11
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 1);
      add(0, 0, 32'h00, 0, 32'h00, 0, 0, 1);  // taken held
      add(0, 1, 32'h40, 1, 32'h40, 0, 1, 1);  // forwarded 10
      add(0, 1, 32'h44, 1, 32'h40, 0, 1, 0);  // entry0 -> 01, entry1 untouched
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 0);  // entry0 01
      add(0, 1, 32'h40, 1, 32'h40, 1, 1, 1);  // forwarded 10
      add(0, 1, 32'h40, 1, 32'h44, 1, 1, 1);  // different index: entry0 10
      add(0, 1, 32'h44, 0, 32'h00, 0, 1, 1);  // entry1 10
      add(0, 1, 32'h48, 0, 32'h00, 0, 1, 0);  // entry2 untouched
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // entry0 11
      add(1, 1, 32'h40, 1, 32'h40, 1, 0, 0);  // reset beats update/lookup
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 0);  // learned state gone
      add(0, 1, 32'h44, 0, 32'h00, 0, 1, 0);
      add(0, 0, 32'h00, 1, 32'h40, 0, 0, 0);  // 00
      add(0, 0, 32'h00, 1, 32'h40, 0, 0, 0);  // 00
      add(0, 0, 32'h00, 1, 32'h40, 0, 0, 0);  // 00, no wrap
      add(0, 0, 32'h00, 1, 32'h40, 1, 0, 0);  // 01
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 0);
      add(0, 0, 32'h00, 1, 32'h440, 1, 0, 0); // aliases entry0 -> 10
      add(0, 1, 32'h40, 0, 32'h00, 0, 1, 1);

      foreach (vq[i]) begin
         drive(vq[i].r, vq[i].pv, vq[i].ppc, vq[i].uv, vq[i].upc, vq[i].ut);
         check($sformatf("bim_vec%0d", i), {5'd0, ov0, tk0, ghr0},
               {5'd0, vq[i].exp_ov, vq[i].exp_tk, 1'b0});
      end

      // gshare: history and pre-shift indexing
      drive(1, 0, 32'h00, 0, 32'h00, 0);
      drive(1, 0, 32'h00, 0, 32'h00, 0);
      check("gsh_reset_ghr", {6'd0, ghr1}, 8'd0);
      drive(0, 0, 32'h00, 1, 32'h4C, 1);      // ghr 00 -> entry3 = 10
      check("gsh_ghr_01", {6'd0, ghr1}, 8'd1);
      drive(0, 0, 32'h00, 1, 32'h4C, 1);      // ghr 01 -> entry2 = 10
      check("gsh_ghr_11", {6'd0, ghr1}, 8'd3);
      drive(0, 1, 32'h40, 0, 32'h00, 0);      // 0 ^ 3 -> entry3
      check("gsh_lookup_e3", {6'd0, ov1, tk1}, 8'd3);
      drive(0, 1, 32'h4C, 0, 32'h00, 0);      // 3 ^ 3 -> entry0 (01)
      check("gsh_lookup_e0", {6'd0, ov1, tk1}, 8'd2);
      drive(0, 1, 32'h40, 1, 32'h40, 0);      // both use ghr 11 -> entry3 = 01
      check("gsh_preshift_fwd", {6'd0, ov1, tk1}, 8'd2);
      check("gsh_ghr_10", {6'd0, ghr1}, 8'd2);
      drive(0, 1, 32'h40, 0, 32'h00, 0);      // 0 ^ 2 -> entry2 (10)
      check("gsh_lookup_e2", {6'd0, ov1, tk1}, 8'd3);
      drive(1, 1, 32'h40, 1, 32'h40, 1);
      check("gsh_rst_ghr", {6'd0, ghr1}, 8'd0);
      check("gsh_rst_ov", {7'd0, ov1}, 8'd0);

      // Three-bit counters: reset value 3, floor at 0
      drive(1, 0, 32'h00, 0, 32'h00, 0);
      drive(1, 0, 32'h00, 0, 32'h00, 0);
      drive(0, 1, 32'h40, 0, 32'h00, 0);      // 3 -> MSB 0
      check("c3_reset_val", {6'd0, ov2, tk2}, 8'd2);
      for (int i = 0; i < 4; i++) drive(0, 0, 32'h00, 1, 32'h40, 0);  // 2,1,0,0
      for (int i = 0; i < 3; i++) drive(0, 0, 32'h00, 1, 32'h40, 1);  // 1,2,3
      drive(0, 1, 32'h40, 0, 32'h00, 0);
      check("c3_no_wrap", {6'd0, ov2, tk2}, 8'd2);
      drive(0, 1, 32'h40, 1, 32'h40, 1);      // forwarded 4
      check("c3_fwd_4", {6'd0, ov2, tk2}, 8'd3);
      drive(1, 0, 32'h00, 0, 32'h00, 0);
      drive(0, 1, 32'h40, 1, 32'h40, 1);      // 3 -> 4 forwarded
      check("c3_reset_then_up", {6'd0, ov2, tk2}, 8'd3);
      check("c3_ghr_zero", {7'd0, ghr2}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
